// File: rtl/outrow_arb_if.sv
// outrow_arb_if: column-write / output-stream bundle for the output-row collector.
//   master: run control (start, length), column writes (rready, in_data), out_pop
//   slave : column acks (read), FIFO head (out_valid, out_data, out_col),
//           run status (count, done, err)
interface outrow_arb_if #(
    parameter int unsigned COLS = 4,
    parameter int unsigned W    = 11,
    parameter int unsigned LW   = 6,
    parameter int unsigned CW   = 2
);
    logic                   start;
    logic [LW-1:0]          length  [0:COLS-1];
    logic [COLS-1:0]        rready;
    logic [W-1:0]           in_data [0:COLS-1];
    logic [COLS-1:0]        read;
    logic                   out_valid;
    logic [W-1:0]           out_data;
    logic [CW-1:0]          out_col;
    logic                   out_pop;
    logic [7:0]             count;
    logic                   done;
    logic                   err;

    modport master (
        output start, length, rready, in_data, out_pop,
        input  read, out_valid, out_data, out_col, count, done, err
    );

    modport slave (
        input  start, length, rready, in_data, out_pop,
        output read, out_valid, out_data, out_col, count, done, err
    );
endinterface

// File: rtl/outrow_arb.sv
// outrow_arb: shares one output stream between the bottom-row column write ports.
// Grants column writes round-robin, tags accepted words with their column in a
// first-word-fall-through FIFO, counts words per column against sampled lengths
// and flags completion (done) and writes to already-complete columns (err).
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : outrow_arb_if slave modport (see interface header)
module outrow_arb #(
    parameter int unsigned COLS  = 4,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 11,
    parameter int unsigned LW    = 6
) (
    input  logic         clk,
    input  logic         rst,
    outrow_arb_if.slave  bus
);
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned EW = CW + W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q [COLS];
    logic [LW-1:0]   len_d [COLS];
    logic [LW-1:0]   cnt_q [COLS];
    logic [LW-1:0]   cnt_d [COLS];
    logic [CW-1:0]   rr_q, rr_d;
    logic [COLS-1:0] read_q, read_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OW-1:0]   occ_q, occ_d;
    logic            full_q, full_d;
    logic            valid_q, valid_d;
    logic [7:0]      count_q, count_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic [EW-1:0]   mem_q [DEPTH];

    logic [COLS-1:0] complete_c;
    logic [COLS-1:0] elig_c;
    logic [CW-1:0]   sel_c [COLS];
    logic            arb_en_c;
    logic            grant_hit_c;
    logic [CW-1:0]   grant_idx_c;
    logic            push_c;
    logic            pop_c;
    logic [EW-1:0]   push_word_c;
    logic [EW-1:0]   head_c;

    // Per-column completion and eligibility (hold off during the ack cycle)
    always_comb begin
        for (int unsigned c = 0; c < COLS; c++) begin
            complete_c[c] = (cnt_q[c] == len_q[c]);
        end
        elig_c = bus.rready & ~read_q;
    end

    // Round-robin search order starting at the rr pointer
    always_comb begin
        for (int unsigned i = 0; i < COLS; i++) begin
            sel_c[i] = CW'((32'(rr_q) + 32'(i)) % 32'(COLS));
        end
    end

    // Next-state, arbitration, counters and FIFO pointers
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        read_d      = '0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        occ_d       = occ_q;
        count_d     = count_q;
        err_d       = err_q;
        grant_hit_c = 1'b0;
        grant_idx_c = '0;
        push_c      = 1'b0;
        push_word_c = '0;

        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.start) state_d = RUN;
                     else if (&complete_c) state_d = DONE;
            DONE:    if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase

        // Grants only while running, never on a start edge, never into a full FIFO
        arb_en_c = (state_q != IDLE) && !full_q && !bus.start;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (arb_en_c && !grant_hit_c && elig_c[sel_c[i]]) begin
                grant_hit_c = 1'b1;
                grant_idx_c = sel_c[i];
            end
        end

        if (grant_hit_c) begin
            read_d[grant_idx_c] = 1'b1;
            rr_d = (32'(grant_idx_c) == COLS - 1) ? '0 : grant_idx_c + CW'(1);
            if (!complete_c[grant_idx_c]) begin
                push_c               = 1'b1;
                push_word_c          = {grant_idx_c, bus.in_data[grant_idx_c]};
                cnt_d[grant_idx_c]   = cnt_q[grant_idx_c] + LW'(1);
                if (count_q != 8'hFF) count_d = count_q + 8'd1;
            end else begin
                // Late word on a finished column: ack and drop
                err_d = 1'b1;
            end
        end

        pop_c = bus.out_pop && valid_q;
        if (push_c) wptr_d = wptr_q + AW'(1);
        if (pop_c)  rptr_d = rptr_q + AW'(1);
        occ_d = occ_q + OW'(push_c) - OW'(pop_c);

        // Start re-arms the run from any state
        if (bus.start) begin
            len_d   = bus.length;
            for (int unsigned c = 0; c < COLS; c++) cnt_d[c] = '0;
            rr_d    = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            occ_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end

        full_d  = (occ_d == OW'(DEPTH));
        valid_d = (occ_d != '0);
        done_d  = (state_d == DONE);
    end

    // State and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int unsigned c = 0; c < COLS; c++) begin
                len_q[c] <= '0;
                cnt_q[c] <= '0;
            end
            rr_q    <= '0;
            read_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            read_q  <= read_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            valid_q <= valid_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_c) begin
            mem_q[wptr_q] <= push_word_c;
        end
    end

    // Head word is zero whenever the FIFO is empty
    assign head_c        = valid_q ? mem_q[rptr_q] : '0;
    assign bus.out_data  = head_c[W-1:0];
    assign bus.out_col   = head_c[EW-1:W];
    assign bus.out_valid = valid_q;
    assign bus.read      = read_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_outrow_arb.sv
// tb_outrow_arb: directed bench for outrow_arb with per-column writer models.
module tb_outrow_arb;
    logic clk;
    logic rst;

    outrow_arb_if #(.COLS(4), .W(11), .LW(6), .CW(2)) bus ();

    outrow_arb #(.COLS(4), .DEPTH(16), .W(11), .LW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total;
    int bad;
    int multi;
    int dbl;

    logic [10:0] wdat [4][24];
    int          wn [4];
    int          wi [4];
    logic [3:0]  prev_read;
    int          gq [$];
    int          pcol [$];
    int          pdat [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_writers();
        for (int c = 0; c < 4; c++) begin
            if (wi[c] < wn[c]) begin
                bus.rready[c]  = 1'b1;
                bus.in_data[c] = wdat[c][wi[c]];
            end else begin
                bus.rready[c]  = 1'b0;
                bus.in_data[c] = '0;
            end
        end
    endtask

    // One cycle: log acks/pops seen since the last edge, then update writers
    task automatic tick();
        @(negedge clk);
        for (int c = 0; c < 4; c++) begin
            if (bus.read[c]) begin
                gq.push_back(c);
                if (wi[c] < wn[c]) wi[c]++;
                if (prev_read[c]) dbl++;
            end
        end
        if ($countones(bus.read) > 1) multi++;
        prev_read = bus.read;
        if (bus.out_pop && bus.out_valid) begin
            pcol.push_back(int'(bus.out_col));
            pdat.push_back(int'(bus.out_data));
        end
        drive_writers();
    endtask

    task automatic setup(input int l0, input int l1, input int l2, input int l3, input logic pop);
        gq.delete();
        pcol.delete();
        pdat.delete();
        for (int c = 0; c < 4; c++) begin
            wn[c] = 0;
            wi[c] = 0;
        end
        bus.length[0] = 6'(l0);
        bus.length[1] = 6'(l1);
        bus.length[2] = 6'(l2);
        bus.length[3] = 6'(l3);
        bus.out_pop   = pop;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start = 1'b1;
        drive_writers();
        @(negedge clk);
        bus.start = 1'b0;
        prev_read = '0;
    endtask

    task automatic scen2(input string pfx);
        setup(3, 3, 3, 3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            wn[c] = 3;
            for (int i = 0; i < 3; i++) wdat[c][i] = 11'(c * 10 + i);
        end
        start_pulse();
        repeat (30) tick();
        check({pfx, "_ngrants"}, gq.size(), 12);
        check({pfx, "_npops"}, pdat.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < gq.size())
                check($sformatf("%s_grant%0d", pfx, k), gq[k], k % 4);
            if (k < pdat.size()) begin
                check($sformatf("%s_col%0d", pfx, k), pcol[k], k % 4);
                check($sformatf("%s_data%0d", pfx, k), pdat[k], (k % 4) * 10 + k / 4);
            end
        end
        check({pfx, "_count"}, bus.count, 12);
        check({pfx, "_done"}, bus.done, 1);
        check({pfx, "_err"}, bus.err, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        multi = 0;
        dbl   = 0;
        prev_read = '0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.out_pop = 1'b0;
        bus.rready = '0;
        for (int c = 0; c < 4; c++) begin
            bus.length[c]  = '0;
            bus.in_data[c] = '0;
            wn[c] = 0;
            wi[c] = 0;
        end

        // Reset values
        #2;
        check("rst_read", bus.read, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_col", bus.out_col, 0);
        check("rst_count", bus.count, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single column, five words
        setup(5, 0, 0, 0, 1'b1);
        wn[0] = 5;
        for (int i = 0; i < 5; i++) wdat[0][i] = 11'(i);
        start_pulse();
        repeat (20) tick();
        check("t1_ngrants", gq.size(), 5);
        check("t1_npops", pdat.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < pdat.size()) begin
                check($sformatf("t1_data%0d", k), pdat[k], k);
                check($sformatf("t1_col%0d", k), pcol[k], 0);
            end
        end
        check("t1_count", bus.count, 5);
        check("t1_done", bus.done, 1);
        check("t1_err", bus.err, 0);

        // All columns contending
        scen2("t2");

        // FIFO full backpressure
        setup(20, 0, 0, 0, 1'b0);
        wn[0] = 20;
        for (int i = 0; i < 20; i++) wdat[0][i] = 11'(i);
        start_pulse();
        repeat (45) tick();
        check("t3_ngrants", gq.size(), 16);
        check("t3_count", bus.count, 16);
        check("t3_rready", bus.rready[0], 1);
        check("t3_read_low", bus.read[0], 0);
        check("t3_head", bus.out_data, 0);
        check("t3_head_col", bus.out_col, 0);
        bus.out_pop = 1'b1;
        @(posedge clk);
        #1;
        bus.out_pop = 1'b0;
        check("t3_no_grant_pop_edge", bus.read[0], 0);
        @(posedge clk);
        #1;
        check("t3_grant17", bus.read[0], 1);
        check("t3_count17", bus.count, 17);
        check("t3_head2", bus.out_data, 1);

        // Late word on a completed column
        setup(1, 0, 0, 0, 1'b0);
        wn[0] = 2;
        wdat[0][0] = 11'd7;
        wdat[0][1] = 11'd9;
        start_pulse();
        repeat (15) tick();
        check("t4_ngrants", gq.size(), 2);
        check("t4_count", bus.count, 1);
        check("t4_err", bus.err, 1);
        check("t4_done", bus.done, 1);
        check("t4_valid", bus.out_valid, 1);
        check("t4_head", bus.out_data, 7);
        bus.out_pop = 1'b1;
        @(posedge clk);
        #1;
        bus.out_pop = 1'b0;
        check("t4_empty", bus.out_valid, 0);

        // Asynchronous reset mid-run, then rerun
        setup(3, 3, 3, 3, 1'b1);
        for (int c = 0; c < 4; c++) begin
            wn[c] = 3;
            for (int i = 0; i < 3; i++) wdat[c][i] = 11'(c * 10 + i);
        end
        start_pulse();
        repeat (5) tick();
        check("t5_pre_count_nz", 32'(bus.count != 0), 1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_read", bus.read, 0);
        check("t5_valid", bus.out_valid, 0);
        check("t5_count", bus.count, 0);
        check("t5_done", bus.done, 0);
        #1;
        rst = 1'b1;
        scen2("t5r");

        // All-zero lengths
        setup(0, 0, 0, 0, 1'b1);
        drive_writers();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("t6_done_e0", bus.done, 0);
        @(posedge clk);
        #1;
        check("t6_done_e1", bus.done, 1);
        prev_read = '0;
        repeat (4) tick();
        check("t6_ngrants", gq.size(), 0);
        check("t6_count", bus.count, 0);

        check("multi_grant", multi, 0);
        check("double_ack", dbl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
